song_sequencer: RTL and testbench

- Parametrised successor to the single-song note ROM. It sequences any of NUM_SONGS songs stored in one shared synchronous song ROM.
- It fetches 16-bit entries, dispatches notes to NUM_VOICES note players (chords), and times waits in beats.
- It supports pause/resume, song switching mid-play and an explicit end-of-song marker.
- Sits between the song ROM and the note-player bank; clocked by the system clock, timed by the beat pulse.

---
 rtl/song_pkg.sv | 38 +++
 rtl/voice_alloc.sv | 21 ++
 rtl/song_sequencer.sv | 165 ++++++++++++++++
 tb/tb_song_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: entry layout, FSM states and the end marker.
package song_pkg;

   localparam int unsigned PKG_SONG_W     = 2;
   localparam int unsigned PKG_OFS_W      = 5;
   localparam int unsigned PKG_NUM_VOICES = 3;

   localparam int unsigned ENT_NOTE_W = 6;
   localparam int unsigned ENT_DUR_W  = 6;
   localparam int unsigned ENT_META_W = 3;
   localparam int unsigned ENT_W      = 1 + ENT_NOTE_W + ENT_DUR_W + ENT_META_W;

   localparam int unsigned ENT_META_LSB = 0;
   localparam int unsigned ENT_DUR_LSB  = ENT_META_W;
   localparam int unsigned ENT_NOTE_LSB = ENT_META_W + ENT_DUR_W;
   localparam int unsigned ENT_WAIT_BIT = ENT_W - 1;

   typedef struct packed {
      logic                  is_wait;
      logic [ENT_NOTE_W-1:0] note;
      logic [ENT_DUR_W-1:0]  dur;
      logic [ENT_META_W-1:0] meta;
   } entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_DECODE,
      ST_WAIT,
      ST_ADV,
      ST_DONE
   } state_e;

   // A wait of zero beats terminates the song.
   localparam entry_t END_MARKER = '{is_wait: 1'b1, note: '0, dur: '0, meta: '0};

endpackage

// File: rtl/voice_alloc.sv
// Lowest-index free voice picker: one-hot grant of the first clear bit in blocked_i.
module voice_alloc #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0] blocked_i,
   output logic [N-1:0] grant_o,
   output logic         valid_o
);

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!blocked_i[i] && !valid_o) begin
            grant_o[i] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks one song of a shared ROM, dispatching notes to free voices and timing waits in beats.
module song_sequencer
   import song_pkg::*;
#(
   parameter int unsigned SONG_W     = PKG_SONG_W,
   parameter int unsigned OFS_W      = PKG_OFS_W,
   parameter int unsigned NUM_VOICES = PKG_NUM_VOICES,
   parameter int unsigned NOTE_W     = ENT_NOTE_W,
   parameter int unsigned DUR_W      = ENT_DUR_W,
   parameter int unsigned META_W     = ENT_META_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         play,
   input  logic [SONG_W-1:0]            song_sel,
   input  logic                         beat,
   output logic [SONG_W+OFS_W-1:0]      rom_addr,
   input  logic [NOTE_W+DUR_W+META_W:0] rom_dout,
   input  logic [NUM_VOICES-1:0]        voice_busy,
   output logic [NUM_VOICES-1:0]        note_load,
   output logic [NOTE_W-1:0]            note_out,
   output logic [DUR_W-1:0]             dur_out,
   output logic [META_W-1:0]            meta_out,
   output logic                         song_done,
   output logic [SONG_W-1:0]            cur_song
);

   localparam int unsigned ENTRY_W = 1 + NOTE_W + DUR_W + META_W;
   localparam logic [OFS_W-1:0] LAST_OFS = '1;

   state_e                    state_q;
   logic [OFS_W-1:0]          ofs_q;
   logic [SONG_W-1:0]         song_q;
   logic [ENTRY_W-1:0]        entry_q;
   logic [DUR_W-1:0]          beat_cnt_q;
   logic                      ended_q;
   logic [SONG_W+OFS_W-1:0]   rom_addr_q;
   logic [NUM_VOICES-1:0]     note_load_q;
   logic [NOTE_W-1:0]         note_q;
   logic [DUR_W-1:0]          dur_q;
   logic [META_W-1:0]         meta_q;
   logic                      done_q;

   logic                      e_wait;
   logic [NOTE_W-1:0]         e_note;
   logic [DUR_W-1:0]          e_dur;
   logic [META_W-1:0]         e_meta;
   logic [OFS_W-1:0]          ofs_nxt;
   logic                      switch_req;
   logic [NUM_VOICES-1:0]     grant;
   logic                      grant_vld;

   assign e_wait     = entry_q[ENTRY_W-1];
   assign e_note     = entry_q[DUR_W+META_W +: NOTE_W];
   assign e_dur      = entry_q[META_W +: DUR_W];
   assign e_meta     = entry_q[0 +: META_W];
   assign ofs_nxt    = ofs_q + OFS_W'(1);
   assign switch_req = (song_sel != song_q);

   // A voice loaded last cycle may not show busy yet, so it is excluded too.
   voice_alloc #(.N(NUM_VOICES)) u_voice_alloc (
      .blocked_i (voice_busy | note_load_q),
      .grant_o   (grant),
      .valid_o   (grant_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ofs_q       <= '0;
         song_q      <= '0;
         entry_q     <= '0;
         beat_cnt_q  <= '0;
         ended_q     <= 1'b0;
         rom_addr_q  <= '0;
         note_load_q <= '0;
         note_q      <= '0;
         dur_q       <= '0;
         meta_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         note_load_q <= '0;
         done_q      <= 1'b0;
         if (state_q != ST_DONE && (!play || switch_req)) begin
            ended_q <= 1'b0;
         end
         if (switch_req && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_q <= ST_IDLE;
            ofs_q   <= '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (play && !ended_q) begin
                     song_q     <= song_sel;
                     ofs_q      <= '0;
                     rom_addr_q <= {song_sel, {OFS_W{1'b0}}};
                     state_q    <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  if (play) begin
                     state_q <= ST_LATCH;
                  end
               end
               ST_LATCH: begin
                  entry_q <= rom_dout;
                  state_q <= ST_DECODE;
               end
               ST_DECODE: begin
                  if (play) begin
                     if (!e_wait) begin
                        if (grant_vld) begin
                           note_load_q <= grant;
                           note_q      <= e_note;
                           dur_q       <= e_dur;
                           meta_q      <= e_meta;
                           state_q     <= ST_ADV;
                        end
                     end else if (e_dur == '0) begin
                        state_q <= ST_DONE;
                     end else begin
                        beat_cnt_q <= e_dur;
                        state_q    <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (play && beat) begin
                     beat_cnt_q <= beat_cnt_q - DUR_W'(1);
                     if (beat_cnt_q == DUR_W'(1)) begin
                        state_q <= ST_ADV;
                     end
                  end
               end
               ST_ADV: begin
                  if (play) begin
                     if (ofs_q == LAST_OFS) begin
                        state_q <= ST_DONE;
                     end else begin
                        ofs_q      <= ofs_nxt;
                        rom_addr_q <= {song_q, ofs_nxt};
                        state_q    <= ST_FETCH;
                     end
                  end
               end
               ST_DONE: begin
                  done_q  <= 1'b1;
                  ended_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign rom_addr  = rom_addr_q;
   assign note_load = note_load_q;
   assign note_out  = note_q;
   assign dur_out   = dur_q;
   assign meta_out  = meta_q;
   assign song_done = done_q;
   assign cur_song  = song_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: cycle reference model plus directed literal checks and random play.
module tb_song_sequencer;
   import song_pkg::*;

   localparam int M_IDLE = 0, M_ADDR = 1, M_DATA = 2, M_EXEC = 3, M_BEATS = 4, M_STEP = 5, M_END = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1, play = 1'b0, beat = 1'b0;
   logic [1:0] song_sel = 2'd0;
   logic [6:0] rom_addr;
   logic [15:0] rom_dout;
   logic [2:0] voice_busy, note_load, meta_out;
   logic [5:0] note_out, dur_out;
   logic       song_done;
   logic [1:0] cur_song;

   entry_t     rom [128];
   int         pc [3];
   logic       busy_auto = 1'b1;
   logic [2:0] man_busy = 3'b000;

   int n_checks = 0, n_err = 0, cyc = 0, done_cnt = 0, beats_seen = 0;
   logic [2:0] ld_mask [$];
   int         ld_note [$], ld_dur [$], ld_meta [$], ld_cyc [$], ld_beats [$];

   // reference model state
   int         m_ph = M_IDLE, m_ofs = 0, m_song = 0, m_cnt = 0;
   bit         m_ended = 1'b0;
   entry_t     m_entry;
   logic [6:0] e_addr = '0;
   logic [2:0] e_load = '0, e_meta = '0;
   logic [5:0] e_note = '0, e_dur = '0;
   logic       e_done = 1'b0;

   song_sequencer dut (
      .clk(clk), .reset(reset), .play(play), .song_sel(song_sel), .beat(beat),
      .rom_addr(rom_addr), .rom_dout(rom_dout), .voice_busy(voice_busy),
      .note_load(note_load), .note_out(note_out), .dur_out(dur_out), .meta_out(meta_out),
      .song_done(song_done), .cur_song(cur_song)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= rom[rom_addr];

   // Note players: a loaded voice stays busy for its duration in cycles.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) pc[i] = 0;
         else if (note_load[i]) pc[i] = int'(dur_out);
         else if (pc[i] > 0) pc[i] = pc[i] - 1;
      end
   end
   assign voice_busy = busy_auto ? {pc[2] != 0, pc[1] != 0, pc[0] != 0} : man_busy;

   function automatic entry_t mk(input int w, input int n, input int d, input int m);
      entry_t e;
      e.is_wait = 1'(w);
      e.note    = 6'(n);
      e.dur     = 6'(d);
      e.meta    = 3'(m);
      return e;
   endfunction

   task automatic model_step();
      int ph0;
      bit ended0, sw, got;
      logic [2:0] prev;
      ph0 = m_ph; ended0 = m_ended; prev = e_load; got = 1'b0;
      if (reset) begin
         m_ph = M_IDLE; m_ofs = 0; m_song = 0; m_cnt = 0; m_ended = 1'b0; m_entry = '0;
         e_addr = '0; e_load = '0; e_note = '0; e_dur = '0; e_meta = '0; e_done = 1'b0;
         return;
      end
      sw = (int'(song_sel) != m_song);
      e_load = '0;
      e_done = 1'b0;
      if (ph0 != M_END && (!play || sw)) m_ended = 1'b0;
      if (sw && ph0 != M_IDLE && ph0 != M_END) begin
         m_ph = M_IDLE; m_ofs = 0;
      end else begin
         case (ph0)
            M_IDLE: if (play && !ended0) begin
               m_song = int'(song_sel); m_ofs = 0;
               e_addr = 7'(m_song * 32); m_ph = M_ADDR;
            end
            M_ADDR: if (play) m_ph = M_DATA;
            M_DATA: begin m_entry = rom[e_addr]; m_ph = M_EXEC; end
            M_EXEC: if (play) begin
               if (!m_entry.is_wait) begin
                  for (int i = 0; i < 3; i++) begin
                     if (!got && !voice_busy[i] && !prev[i]) begin
                        got = 1'b1; e_load = 3'(1 << i);
                     end
                  end
                  if (got) begin
                     e_note = m_entry.note; e_dur = m_entry.dur; e_meta = m_entry.meta;
                     m_ph = M_STEP;
                  end
               end else if (m_entry.dur == 0) m_ph = M_END;
               else begin m_cnt = int'(m_entry.dur); m_ph = M_BEATS; end
            end
            M_BEATS: if (play && beat) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_ph = M_STEP;
            end
            M_STEP: if (play) begin
               if (m_ofs == 31) m_ph = M_END;
               else begin m_ofs = m_ofs + 1; e_addr = 7'(m_song * 32 + m_ofs); m_ph = M_ADDR; end
            end
            M_END: begin e_done = 1'b1; m_ended = 1'b1; m_ph = M_IDLE; end
            default: m_ph = M_IDLE;
         endcase
      end
   endtask

   // Model update, every-cycle compare and event log.
   always @(posedge clk) begin
      model_step();
      if (beat) beats_seen = beats_seen + 1;
      #1;
      n_checks = n_checks + 1;
      if ({rom_addr, note_load, note_out, dur_out, meta_out, song_done, cur_song} !==
          {e_addr, e_load, e_note, e_dur, e_meta, e_done, 2'(m_song)}) begin
         n_err = n_err + 1;
         if (n_err < 30)
            $display("FAIL model cyc=%0d addr=%h/%h load=%b/%b note=%0d/%0d dur=%0d/%0d meta=%0d/%0d done=%b/%b song=%0d/%0d (got/exp)",
                     cyc, rom_addr, e_addr, note_load, e_load, note_out, e_note, dur_out, e_dur,
                     meta_out, e_meta, song_done, e_done, cur_song, m_song);
      end
      if (note_load != 3'b000) begin
         ld_mask.push_back(note_load); ld_note.push_back(int'(note_out));
         ld_dur.push_back(int'(dur_out)); ld_meta.push_back(int'(meta_out));
         ld_cyc.push_back(cyc); ld_beats.push_back(beats_seen);
      end
      if (song_done) done_cnt = done_cnt + 1;
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_checks = n_checks + 1;
      if (got != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset = 1'b1; play = 1'b0; beat = 1'b0; busy_auto = 1'b1; man_busy = 3'b000;
      for (int a = 0; a < 128; a++) rom[a] = END_MARKER;
   endtask

   task automatic release_reset(input int s);
      song_sel = 2'(s);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ld_mask.delete(); ld_note.delete(); ld_dur.delete(); ld_meta.delete();
      ld_cyc.delete(); ld_beats.delete();
      done_cnt = 0; beats_seen = 0;
   endtask

   task automatic wait_loads(input int n, input int budget, input string nm);
      int k = 0;
      while (ld_mask.size() < n && k < budget) begin @(posedge clk); #2; k++; end
      chk(nm, ld_mask.size(), n);
   endtask

   task automatic wait_done(input int budget, input string nm);
      int k = 0;
      while (done_cnt < 1 && k < budget) begin @(posedge clk); #2; k++; end
      chk(nm, done_cnt, 1);
   endtask

   task automatic pulse_beat(input int gap);
      beat = 1'b1; @(negedge clk); beat = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   function automatic int q_at(input int q [$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int flag;
      for (int a = 0; a < 128; a++) rom[a] = END_MARKER;

      // chord on three idle voices
      hold_reset();
      rom[0] = mk(0, 52, 48, 0); rom[1] = mk(0, 56, 32, 0); rom[2] = mk(0, 59, 16, 0); rom[3] = END_MARKER;
      release_reset(0);
      chk("reset_addr", int'(rom_addr), 0);
      chk("reset_load", int'(note_load), 0);
      play = 1'b1;
      wait_loads(3, 40, "chord_loads");
      wait_done(40, "chord_done");
      repeat (20) @(negedge clk);
      chk("chord_done_once", done_cnt, 1);
      chk("chord_mask0", ld_mask.size() > 0 ? int'(ld_mask[0]) : -1, 1);
      chk("chord_mask1", ld_mask.size() > 1 ? int'(ld_mask[1]) : -1, 2);
      chk("chord_mask2", ld_mask.size() > 2 ? int'(ld_mask[2]) : -1, 4);
      chk("chord_notes", q_at(ld_note, 0) * 10000 + q_at(ld_note, 1) * 100 + q_at(ld_note, 2), 525659);
      chk("chord_durs", q_at(ld_dur, 0) * 10000 + q_at(ld_dur, 1) * 100 + q_at(ld_dur, 2), 483216);
      chk("chord_gap01", q_at(ld_cyc, 1) - q_at(ld_cyc, 0), 4);
      chk("chord_gap12", q_at(ld_cyc, 2) - q_at(ld_cyc, 1), 4);

      // three-beat wait before a note
      hold_reset();
      rom[32] = mk(1, 0, 3, 0); rom[33] = mk(0, 10, 5, 1);
      release_reset(1);
      play = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 6 && ld_mask.size() == 0; i++) pulse_beat(5);
      chk("wait_loads", ld_mask.size(), 1);
      chk("wait_beats_at_load", q_at(ld_beats, 0), 3);
      chk("wait_note", q_at(ld_note, 0), 10);
      chk("wait_meta", q_at(ld_meta, 0), 1);

      // pause mid-wait with two beats left
      hold_reset();
      rom[32] = mk(1, 0, 4, 0); rom[33] = mk(0, 11, 5, 2);
      release_reset(1);
      play = 1'b1;
      repeat (8) @(negedge clk);
      pulse_beat(5); pulse_beat(5);
      play = 1'b0;
      for (int i = 0; i < 5; i++) pulse_beat(3);
      repeat (5) @(negedge clk);
      chk("pause_no_load", ld_mask.size(), 0);
      play = 1'b1;
      for (int i = 0; i < 6 && ld_mask.size() == 0; i++) pulse_beat(5);
      chk("pause_beats_at_load", q_at(ld_beats, 0), 9);

      // stall with all voices busy, then free voice 1
      hold_reset();
      rom[64] = mk(0, 20, 40, 0); rom[65] = mk(0, 21, 40, 1);
      rom[66] = mk(0, 22, 40, 2); rom[67] = mk(0, 23, 40, 3);
      release_reset(2);
      play = 1'b1;
      wait_loads(3, 40, "stall_first3");
      @(negedge clk); busy_auto = 1'b0; man_busy = 3'b111;
      repeat (15) @(negedge clk);
      chk("stall_hold", ld_mask.size(), 3);
      man_busy = 3'b101;
      wait_loads(4, 10, "stall_release");
      chk("stall_mask", ld_mask.size() > 3 ? int'(ld_mask[3]) : -1, 2);
      chk("stall_note", q_at(ld_note, 3), 23);

      // reset while a note is pending in decode
      hold_reset();
      rom[64] = mk(0, 20, 40, 0); rom[65] = mk(0, 21, 40, 1);
      rom[66] = mk(0, 22, 40, 2); rom[67] = mk(0, 23, 40, 3);
      release_reset(2);
      play = 1'b1;
      wait_loads(3, 40, "rst_first3");
      repeat (10) @(negedge clk);
      chk("rst_pre_note", int'(note_out), 22);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_load", int'(note_load), 0);
      chk("rst_outs", int'({rom_addr, note_out, dur_out, meta_out, song_done, cur_song}), 0);
      chk("rst_no4th", ld_mask.size(), 3);
      @(negedge clk); reset = 1'b0; play = 1'b0;

      // song switch 0 -> 2 during a wait
      hold_reset();
      rom[0] = mk(1, 0, 10, 0); rom[64] = mk(0, 30, 4, 0);
      release_reset(0);
      play = 1'b1;
      repeat (8) @(negedge clk);
      song_sel = 2'd2;
      @(posedge clk); @(posedge clk); #1;
      chk("switch_addr", int'(rom_addr), 'h40);
      chk("switch_song", int'(cur_song), 2);

      // song with no end marker stops after offset 31
      hold_reset();
      for (int a = 0; a < 32; a++) rom[96 + a] = mk(0, a + 1, 2, 0);
      release_reset(3);
      play = 1'b1;
      flag = 0;
      for (int k = 0; k < 300 && done_cnt == 0; k++) begin
         @(posedge clk); #2;
         if (rom_addr[6:5] != 2'd3) flag++;
      end
      chk("wrap_addr_in_song", flag, 0);
      chk("wrap_loads", ld_mask.size(), 32);
      chk("wrap_done", done_cnt, 1);
      chk("wrap_last_addr", int'(rom_addr), 'h7f);

      // randomized play against the model
      hold_reset();
      for (int a = 0; a < 128; a++) begin
         int r = $urandom_range(0, 99);
         if (r < 65) rom[a] = mk(0, $urandom_range(0, 63), $urandom_range(0, 12), $urandom_range(0, 7));
         else if (r < 93) rom[a] = mk(1, $urandom_range(0, 63), $urandom_range(1, 3), $urandom_range(0, 7));
         else rom[a] = mk(1, $urandom_range(0, 63), 0, $urandom_range(0, 7));
      end
      release_reset(0);
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         play  = ($urandom_range(0, 9) != 0);
         beat  = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 59) == 0) song_sel = 2'($urandom_range(0, 3));
         if (k % 500 == 499) busy_auto = ~busy_auto;
         man_busy = 3'($urandom_range(0, 7));
      end
      @(negedge clk); play = 1'b0; beat = 1'b0; reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
